sync_fifo_ft: RTL and testbench

Parametrised synchronous single-clock FIFO. It is the general-purpose buffer for datapath blocks in the design.
- All DEPTH entries are usable, via extra-bit pointers.
- Provides occupancy count, programmable almost-full/almost-empty flags and registered overflow/underflow error pulses.
- Selectable standard (registered read) or first-word-fall-through read mode.

---
 rtl/sync_fifo_ft.sv | 91 +++++++++
 tb/tb_sync_fifo_ft.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ft.sv
// Synchronous single-clock FIFO with occupancy count, programmable almost flags,
// registered overflow/underflow pulses and selectable standard or FWFT read.
module sync_fifo_ft #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 4,
    parameter int unsigned FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             rd_acc;
    logic             wr_acc;
    logic [PW-1:0]    count_nxt;

    // Status decodes: full/empty from the extra-bit pointers, thresholds from count.
    always_comb begin
        full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        empty        = (wr_ptr == rd_ptr);
        almost_full  = (count >= PW'(AF_LEVEL));
        almost_empty = (count <= PW'(AE_LEVEL));
    end

    // A write into a full FIFO is allowed only when a read frees a slot the same cycle.
    always_comb begin
        rd_acc = rd_en & ~empty;
        wr_acc = wr_en & (~full | rd_acc);
    end

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + PW'(1);
            2'b01:   count_nxt = count - PW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
            count     <= count_nxt;
            overflow  <= wr_en & ~wr_acc;
            underflow <= rd_en & ~rd_acc;
        end
    end

    // Storage is never cleared; reset only suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    generate
        if (FWFT == 0) begin : g_std_read
            always_ff @(posedge clk) begin
                if (reset)       rd_data <= '0;
                else if (rd_acc) rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end else begin : g_fwft_read
            // Head word is presented directly; meaningless while empty.
            assign rd_data = mem[rd_ptr[AW-1:0]];
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ft.sv
// Self-checking bench: a standard-read and an FWFT instance share stimulus and are
// compared every cycle against a queue-based model of the FIFO.
module tb_sync_fifo_ft;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wr_data;

    logic [7:0] rd_data0, rd_data1;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0] count0, count1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    logic [7:0] exp_rd;
    logic       exp_ovf;
    logic       exp_unf;

    always #5 clk = ~clk;

    sync_fifo_ft #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_ft #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic verify();
        int sz;
        sz = q.size();
        check("count",      32'(count0), 32'(sz));
        check("full",       32'(full0),  32'(sz == 16));
        check("empty",      32'(empty0), 32'(sz == 0));
        check("afull",      32'(af0),    32'(sz >= 12));
        check("aempty",     32'(ae0),    32'(sz <= 4));
        check("overflow",   32'(ovf0),   32'(exp_ovf));
        check("underflow",  32'(unf0),   32'(exp_unf));
        check("rd_data",    32'(rd_data0), 32'(exp_rd));
        check("f_count",    32'(count1), 32'(sz));
        check("f_full",     32'(full1),  32'(sz == 16));
        check("f_empty",    32'(empty1), 32'(sz == 0));
        check("f_afull",    32'(af1),    32'(sz >= 12));
        check("f_aempty",   32'(ae1),    32'(sz <= 4));
        check("f_overflow", 32'(ovf1),   32'(exp_ovf));
        check("f_underflow",32'(unf1),   32'(exp_unf));
        if (sz > 0) check("f_rd_data", 32'(rd_data1), 32'(q[0]));
    endtask

    // One clock of stimulus: drive at negedge, advance model, check just after posedge.
    task automatic step(input logic rst, input logic we, input logic re, input logic [7:0] wd);
        int sz;
        bit ra, wa;
        reset   = rst;
        wr_en   = we;
        rd_en   = re;
        wr_data = wd;
        sz = q.size();
        if (rst) begin
            q.delete();
            exp_rd  = 8'h00;
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            ra = re && (sz > 0);
            wa = we && ((sz < 16) || ra);
            if (ra) exp_rd = q.pop_front();
            if (wa) q.push_back(wd);
            exp_ovf = we && !wa;
            exp_unf = re && !ra;
        end
        @(posedge clk);
        #1;
        verify();
        @(negedge clk);
    endtask

    initial begin
        int written;
        int guard;
        logic we, re;
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
        exp_rd = 8'h00; exp_ovf = 1'b0; exp_unf = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // Fill, then one rejected write.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        step(1'b0, 1'b1, 1'b0, 8'hAA);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Drain in order, then one rejected read.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("hold_after_underflow", 32'(rd_data0), 32'h0F);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Full pass-through.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'($urandom));
        step(1'b0, 1'b1, 1'b1, 8'h55);
        check("passthru_count", 32'(count0), 32'd16);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        check("passthru_last", 32'(rd_data0), 32'h55);

        // Simultaneous read/write while empty.
        step(1'b0, 1'b1, 1'b1, 8'h33);
        check("empty_rw_underflow", 32'(unf0), 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("empty_rw_data", 32'(rd_data0), 32'h33);

        // Wrap-around stream with occupancy held in 3..10.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'($urandom));
        written = 3;
        guard = 0;
        while (written < 40 && guard < 1000) begin
            we = (q.size() < 10) && ($urandom_range(3, 0) != 0);
            re = (q.size() > 3) && ($urandom_range(1, 0) != 0);
            if (we) written++;
            step(1'b0, we, re, 8'($urandom));
            guard++;
        end
        check("wrap_budget", 32'(guard < 1000), 32'd1);
        while (q.size() > 0) step(1'b0, 1'b0, 1'b1, 8'h00);

        // Reset with entries stored and ops pending.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, 1'b1, 8'hEE);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // FWFT head word appears without a read.
        step(1'b0, 1'b1, 1'b0, 8'h7E);
        check("fwft_head", 32'(rd_data1), 32'h7E);
        step(1'b0, 1'b0, 1'b1, 8'h00);

        // Unconstrained random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(63, 0) == 0, $urandom_range(1, 0) == 1,
                 $urandom_range(1, 0) == 1, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
